id_ex_stage: RTL

//  ID/EX pipeline register of the 5-stage MIPS pipeline. Directly upstream of the EX-stage ALU.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/alu_ctrl_decode.sv | 31 +++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the MIPS pipeline: ALU control codes, ALUOp classes and R-type funct values.
package pipe_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALUOp/funct to 4-bit ALU control decode, shared with the single-cycle CPU.
module alu_ctrl_decode
    import pipe_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl
);

    // Unknown R-type funct values fall back to add.
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_OR:  alu_ctrl = ALU_OR;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctrl = ALU_ADD;
                    FUNCT_SUB: alu_ctrl = ALU_SUB;
                    FUNCT_AND: alu_ctrl = ALU_AND;
                    FUNCT_OR:  alu_ctrl = ALU_OR;
                    FUNCT_SLT: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, decodes the ALU control
// and forwards EX/MEM and MEM/WB results onto the ALU operands.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_alu_op,
    input  logic [5:0]        id_funct,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_ctrl,
    output logic [DATA_W-1:0] ex_alu_in1,
    output logic [DATA_W-1:0] ex_alu_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg
);

    logic [3:0]        alu_ctrl_s;
    logic [DATA_W-1:0] fwd_rs_s;
    logic [DATA_W-1:0] fwd_rt_s;

    logic              valid_r;
    logic [3:0]        alu_ctrl_r;
    logic [DATA_W-1:0] rs_data_r;
    logic [DATA_W-1:0] rt_data_r;
    logic [DATA_W-1:0] imm_r;
    logic [REG_AW-1:0] rs_r;
    logic [REG_AW-1:0] rt_r;
    logic [REG_AW-1:0] dest_r;
    logic              alu_src_r;
    logic              reg_write_r;
    logic              mem_read_r;
    logic              mem_write_r;
    logic              mem_to_reg_r;

    alu_ctrl_decode u_alu_ctrl_decode (
        .alu_op   (id_alu_op),
        .funct    (id_funct),
        .alu_ctrl (alu_ctrl_s)
    );

    // Pipeline register update: reset and flush both load a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_r      <= 1'b0;
            alu_ctrl_r   <= 4'b0000;
            rs_data_r    <= {DATA_W{1'b0}};
            rt_data_r    <= {DATA_W{1'b0}};
            imm_r        <= {DATA_W{1'b0}};
            rs_r         <= {REG_AW{1'b0}};
            rt_r         <= {REG_AW{1'b0}};
            dest_r       <= {REG_AW{1'b0}};
            alu_src_r    <= 1'b0;
            reg_write_r  <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
            mem_to_reg_r <= 1'b0;
        end else if (!stall) begin
            valid_r      <= id_valid;
            alu_ctrl_r   <= alu_ctrl_s;
            rs_data_r    <= id_rs_data;
            rt_data_r    <= id_rt_data;
            imm_r        <= id_imm;
            rs_r         <= id_rs;
            rt_r         <= id_rt;
            dest_r       <= id_reg_dst ? id_rd : id_rt;
            alu_src_r    <= id_alu_src;
            reg_write_r  <= id_reg_write;
            mem_read_r   <= id_mem_read;
            mem_write_r  <= id_mem_write;
            mem_to_reg_r <= id_mem_to_reg;
        end
    end

    // Operand forwarding: the younger EX/MEM result wins over MEM/WB; $zero is never forwarded.
    always_comb begin
        fwd_rs_s = rs_data_r;
        fwd_rt_s = rt_data_r;
        if (mem_reg_write && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == rs_r)) begin
            fwd_rs_s = mem_result;
        end else if (wb_reg_write && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == rs_r)) begin
            fwd_rs_s = wb_result;
        end else begin
            fwd_rs_s = rs_data_r;
        end
        if (mem_reg_write && (mem_rd != {REG_AW{1'b0}}) && (mem_rd == rt_r)) begin
            fwd_rt_s = mem_result;
        end else if (wb_reg_write && (wb_rd != {REG_AW{1'b0}}) && (wb_rd == rt_r)) begin
            fwd_rt_s = wb_result;
        end else begin
            fwd_rt_s = rt_data_r;
        end
    end

    assign ex_valid      = valid_r;
    assign ex_alu_ctrl   = alu_ctrl_r;
    assign ex_alu_in1    = fwd_rs_s;
    assign ex_alu_in2    = alu_src_r ? imm_r : fwd_rt_s;
    assign ex_store_data = fwd_rt_s;
    assign ex_dest       = dest_r;
    assign ex_rs         = rs_r;
    assign ex_rt         = rt_r;
    assign ex_reg_write  = reg_write_r;
    assign ex_mem_read   = mem_read_r;
    assign ex_mem_write  = mem_write_r;
    assign ex_mem_to_reg = mem_to_reg_r;

endmodule
